// File: rtl/btc_miner_ctrl.sv
// Nonce-search sequencer that feeds a double-SHA256 core one nonce at a time.
// Define BTC_MINER_CTRL_HASHCNT_EN to add the saturating hash_count output.
module btc_miner_ctrl #(
    parameter int unsigned NONCE_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        config_use_nonce_in,
    input  logic        config_oneshot,
    input  logic [31:0] nonce_in,
    output logic        hash_start,
    output logic [31:0] hash_nonce,
    input  logic        hash_valid,
    input  logic        hash_meets_target,
    output logic        busy,
    output logic [31:0] nonce,
    output logic        done,
    output logic        nonce_found
`ifdef BTC_MINER_CTRL_HASHCNT_EN
    ,
    output logic [31:0] hash_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [32:0] STEP33 = 33'(NONCE_STEP);

    logic [1:0]  rst_sync_q;
    logic        rst_core_n;

    state_t      state_q;
    logic [31:0] cur_q;
    logic [31:0] nonce_q;
    logic        oneshot_q;
    logic        done_q;
    logic        found_q;
    logic        hash_start_q;
    logic        busy_q;

    logic [32:0] step_sum_d;
    logic        step_carry_d;
    logic        resolve_d;
    logic        job_end_d;
    logic        accept_start_d;

    // Asynchronous assert, synchronous release, so the FSM never leaves reset mid-edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_core_n = rst_sync_q[1];

    assign step_sum_d     = {1'b0, cur_q} + STEP33;
    assign step_carry_d   = step_sum_d[32];
    assign accept_start_d = (state_q == IDLE) && start;
    assign resolve_d      = (state_q == WAIT) && hash_valid;
    assign job_end_d      = hash_meets_target || oneshot_q || step_carry_d;

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            nonce_q      <= '0;
            oneshot_q    <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            hash_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_q        <= config_use_nonce_in ? nonce_in : 32'd0;
                        oneshot_q    <= config_oneshot;
                        done_q       <= 1'b0;
                        found_q      <= 1'b0;
                        hash_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    hash_start_q <= 1'b0;
                    state_q      <= WAIT;
                end
                WAIT: begin
                    if (hash_valid) begin
                        // A hit wins over oneshot and wrap, so nonce_found reflects the result.
                        if (job_end_d) begin
                            nonce_q <= cur_q;
                            done_q  <= 1'b1;
                            found_q <= hash_meets_target;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cur_q        <= step_sum_d[31:0];
                            hash_start_q <= 1'b1;
                            state_q      <= ISSUE;
                        end
                    end
                end
                default: begin
                    hash_start_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

`ifdef BTC_MINER_CTRL_HASHCNT_EN
    logic [31:0] hash_count_q;

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            hash_count_q <= '0;
        end else if (accept_start_d) begin
            hash_count_q <= '0;
        end else if (resolve_d && (hash_count_q != 32'hFFFF_FFFF)) begin
            hash_count_q <= hash_count_q + 32'd1;
        end
    end

    assign hash_count = hash_count_q;
`else
    logic unused_count_d;
    assign unused_count_d = accept_start_d ^ resolve_d;
`endif

    assign hash_start  = hash_start_q;
    assign hash_nonce  = cur_q;
    assign busy        = busy_q;
    assign nonce       = nonce_q;
    assign done        = done_q;
    assign nonce_found = found_q;

endmodule

// File: tb/tb_btc_miner_ctrl.sv
// Directed bench for btc_miner_ctrl: reset, oneshot, search, wrap, busy start,
// back-to-back jobs and reset during a job.
module tb_btc_miner_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        configUseNonceIn;
    logic        configOneshot;
    logic [31:0] nonceIn;
    logic        hashStart;
    logic [31:0] hashNonce;
    logic        hashValid;
    logic        hashMeets;
    logic        busy;
    logic [31:0] nonceOut;
    logic        done;
    logic        nonceFound;
`ifdef BTC_MINER_CTRL_HASHCNT_EN
    logic [31:0] hashCount;
`endif

    int checks = 0;
    int failures = 0;
    int hsCount = 0;

    always #5 clk = ~clk;

    btc_miner_ctrl #(.NONCE_STEP(1)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .config_use_nonce_in (configUseNonceIn),
        .config_oneshot      (configOneshot),
        .nonce_in            (nonceIn),
        .hash_start          (hashStart),
        .hash_nonce          (hashNonce),
        .hash_valid          (hashValid),
        .hash_meets_target   (hashMeets),
        .busy                (busy),
        .nonce               (nonceOut),
        .done                (done),
        .nonce_found         (nonceFound)
`ifdef BTC_MINER_CTRL_HASHCNT_EN
        ,
        .hash_count          (hashCount)
`endif
    );

    // Counts every hash_start pulse seen by the hash core.
    always @(posedge clk) begin
        if (hashStart === 1'b1) hsCount <= hsCount + 1;
    end

    task automatic startJob(input logic useIn, input logic oneshot, input logic [31:0] nin);
        configUseNonceIn = useIn;
        configOneshot    = oneshot;
        nonceIn          = nin;
        start            = 1'b1;
        @(negedge clk);
        start            = 1'b0;
    endtask

    // Acts as the hash core for one attempt; meets is raised only for matchNonce.
    task automatic serveHash(input int delay, input logic matchEn, input logic [31:0] matchNonce,
                             output logic [31:0] seen, output bit ok);
        ok   = 1'b0;
        seen = '0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (hashStart === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) begin
            seen = hashNonce;
            repeat (delay) @(negedge clk);
            hashValid = 1'b1;
            hashMeets = matchEn && (seen == matchNonce);
            @(negedge clk);
            hashValid = 1'b0;
            hashMeets = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (nonceFound !== 1'b0) begin failures++; $display("[TB] FAIL reset_found: got %b expected 0", nonceFound); end
        checks++; if (hashStart !== 1'b0) begin failures++; $display("[TB] FAIL reset_hash_start: got %b expected 0", hashStart); end
        checks++; if (nonceOut !== 32'h0) begin failures++; $display("[TB] FAIL reset_nonce: got %h expected 00000000", nonceOut); end
        checks++; if (hashNonce !== 32'h0) begin failures++; $display("[TB] FAIL reset_hash_nonce: got %h expected 00000000", hashNonce); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_oneshot();
        logic [31:0] seen;
        bit ok;
        int hs0;
        hs0 = hsCount;
        startJob(1'b1, 1'b1, 32'h1234_5678);
        serveHash(5, 1'b0, 32'h0, seen, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL oneshot_issue_timeout: got %b expected 1", ok); end
        checks++; if (seen !== 32'h1234_5678) begin failures++; $display("[TB] FAIL oneshot_hash_nonce: got %h expected 12345678", seen); end
        repeat (3) @(negedge clk);
        checks++; if (hsCount - hs0 != 1) begin failures++; $display("[TB] FAIL oneshot_start_count: got %0d expected 1", hsCount - hs0); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL oneshot_done: got %b expected 1", done); end
        checks++; if (nonceFound !== 1'b0) begin failures++; $display("[TB] FAIL oneshot_found: got %b expected 0", nonceFound); end
        checks++; if (nonceOut !== 32'h1234_5678) begin failures++; $display("[TB] FAIL oneshot_nonce: got %h expected 12345678", nonceOut); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL oneshot_busy: got %b expected 0", busy); end
    endtask

    task automatic test_search();
        logic [31:0] seq [8];
        logic [31:0] seen;
        bit ok;
        int hs0;
        int n;
        for (int i = 0; i < 8; i++) seq[i] = 32'hFFFF_FFFF;
        n = 0;
        ok = 1'b1;
        hs0 = hsCount;
        startJob(1'b0, 1'b0, 32'hAAAA_0000);
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL search_done_cleared: got %b expected 0", done); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL search_busy: got %b expected 1", busy); end
        for (int k = 0; k < 8 && done !== 1'b1 && ok; k++) begin
            serveHash(1, 1'b1, 32'd3, seen, ok);
            if (ok) begin
                seq[n] = seen;
                n++;
            end
        end
        checks++; if (n != 4) begin failures++; $display("[TB] FAIL search_attempts: got %0d expected 4", n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (seq[i] !== 32'(i)) begin failures++; $display("[TB] FAIL search_seq[%0d]: got %h expected %h", i, seq[i], 32'(i)); end
        end
        @(negedge clk);
        checks++; if (hsCount - hs0 != 4) begin failures++; $display("[TB] FAIL search_start_count: got %0d expected 4", hsCount - hs0); end
        checks++; if (nonceOut !== 32'd3) begin failures++; $display("[TB] FAIL search_nonce: got %h expected 00000003", nonceOut); end
        checks++; if (nonceFound !== 1'b1) begin failures++; $display("[TB] FAIL search_found: got %b expected 1", nonceFound); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL search_done: got %b expected 1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL search_busy_end: got %b expected 0", busy); end
`ifdef BTC_MINER_CTRL_HASHCNT_EN
        checks++; if (hashCount !== 32'd4) begin failures++; $display("[TB] FAIL search_hash_count: got %0d expected 4", hashCount); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] seen;
        bit ok;
        startJob(1'b1, 1'b1, 32'h0000_00A5);
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_cleared: got %b expected 0", done); end
        checks++; if (nonceFound !== 1'b0) begin failures++; $display("[TB] FAIL b2b_found_cleared: got %b expected 0", nonceFound); end
        checks++; if (nonceOut !== 32'd3) begin failures++; $display("[TB] FAIL b2b_nonce_held: got %h expected 00000003", nonceOut); end
`ifdef BTC_MINER_CTRL_HASHCNT_EN
        checks++; if (hashCount !== 32'd0) begin failures++; $display("[TB] FAIL b2b_hash_count_clear: got %0d expected 0", hashCount); end
`endif
        serveHash(2, 1'b1, 32'h0000_00A5, seen, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL b2b_issue_timeout: got %b expected 1", ok); end
        checks++; if (nonceFound !== 1'b1) begin failures++; $display("[TB] FAIL b2b_found_oneshot_hit: got %b expected 1", nonceFound); end
        checks++; if (nonceOut !== 32'h0000_00A5) begin failures++; $display("[TB] FAIL b2b_nonce: got %h expected 000000a5", nonceOut); end
    endtask

    task automatic test_wrap();
        logic [31:0] seen;
        bit ok;
        int hs0;
        hs0 = hsCount;
        startJob(1'b1, 1'b0, 32'hFFFF_FFFE);
        serveHash(1, 1'b0, 32'h0, seen, ok);
        checks++; if (seen !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL wrap_first: got %h expected fffffffe", seen); end
        serveHash(1, 1'b0, 32'h0, seen, ok);
        checks++; if (seen !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL wrap_second: got %h expected ffffffff", seen); end
        repeat (3) @(negedge clk);
        checks++; if (hsCount - hs0 != 2) begin failures++; $display("[TB] FAIL wrap_start_count: got %0d expected 2", hsCount - hs0); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL wrap_done: got %b expected 1", done); end
        checks++; if (nonceFound !== 1'b0) begin failures++; $display("[TB] FAIL wrap_found: got %b expected 0", nonceFound); end
        checks++; if (nonceOut !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL wrap_nonce: got %h expected ffffffff", nonceOut); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL wrap_busy: got %b expected 0", busy); end
    endtask

    task automatic test_busy_start();
        logic [31:0] seen;
        bit ok;
        int hs0;
        hs0 = hsCount;
        startJob(1'b1, 1'b0, 32'h0000_0100);
        @(negedge clk);
        configUseNonceIn = 1'b1;
        configOneshot    = 1'b1;
        nonceIn          = 32'hDEAD_BEEF;
        start            = 1'b1;
        @(negedge clk);
        start            = 1'b0;
        checks++; if (hashNonce !== 32'h0000_0100) begin failures++; $display("[TB] FAIL busy_start_cur: got %h expected 00000100", hashNonce); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_start_busy: got %b expected 1", busy); end
        hashValid = 1'b1;
        hashMeets = 1'b0;
        @(negedge clk);
        hashValid = 1'b0;
        serveHash(1, 1'b1, 32'h0000_0101, seen, ok);
        checks++; if (seen !== 32'h0000_0101) begin failures++; $display("[TB] FAIL busy_start_next: got %h expected 00000101", seen); end
        @(negedge clk);
        checks++; if (nonceOut !== 32'h0000_0101) begin failures++; $display("[TB] FAIL busy_start_nonce: got %h expected 00000101", nonceOut); end
        checks++; if (nonceFound !== 1'b1) begin failures++; $display("[TB] FAIL busy_start_found: got %b expected 1", nonceFound); end
        checks++; if (hsCount - hs0 != 2) begin failures++; $display("[TB] FAIL busy_start_count: got %0d expected 2", hsCount - hs0); end
    endtask

    task automatic test_reset_midjob();
        logic [31:0] seen;
        bit ok;
        int hs0;
        startJob(1'b1, 1'b0, 32'h0000_0040);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (nonceOut !== 32'h0) begin failures++; $display("[TB] FAIL midreset_nonce: got %h expected 00000000", nonceOut); end
        checks++; if (hashNonce !== 32'h0) begin failures++; $display("[TB] FAIL midreset_hash_nonce: got %h expected 00000000", hashNonce); end
        @(negedge clk);
        rst_n = 1'b1;
        hs0 = hsCount;
        repeat (3) @(negedge clk);
        hashValid = 1'b1;
        hashMeets = 1'b1;
        @(negedge clk);
        hashValid = 1'b0;
        hashMeets = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (hsCount - hs0 != 0) begin failures++; $display("[TB] FAIL midreset_no_start: got %0d expected 0", hsCount - hs0); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL midreset_done: got %b expected 0", done); end
        checks++; if (nonceFound !== 1'b0) begin failures++; $display("[TB] FAIL midreset_found: got %b expected 0", nonceFound); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy_after: got %b expected 0", busy); end
        checks++; if (nonceOut !== 32'h0) begin failures++; $display("[TB] FAIL midreset_nonce_after: got %h expected 00000000", nonceOut); end
        startJob(1'b1, 1'b1, 32'h0000_0005);
        serveHash(1, 1'b0, 32'h0, seen, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL midreset_restart_timeout: got %b expected 1", ok); end
        checks++; if (nonceOut !== 32'h0000_0005) begin failures++; $display("[TB] FAIL midreset_restart_nonce: got %h expected 00000005", nonceOut); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL midreset_restart_done: got %b expected 1", done); end
    endtask

    initial begin
        rst_n            = 1'b0;
        start            = 1'b0;
        configUseNonceIn = 1'b0;
        configOneshot    = 1'b0;
        nonceIn          = '0;
        hashValid        = 1'b0;
        hashMeets        = 1'b0;
        test_reset();
        test_oneshot();
        test_search();
        test_back_to_back();
        test_wrap();
        test_busy_start();
        test_reset_midjob();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
